if_fetch_align: RTL and testbench

- Fetch-stage producer for the IF/ID pipeline register of the Cortex-M0 core.
- Issues word fetches to instruction memory and buffers returned halfwords.
- Aligns and classifies Thumb 16/32-bit instructions and presents one instruction per cycle to the IF/ID register.
- Handles branch redirect/flush and the LDM/STM/PUSH/POP multi-cycle hold protocol (multiple_pulse/multiple_stable).

---
 rtl/m0_pkg.sv | 32 +++
 rtl/hw_queue.sv | 70 +++++++
 rtl/if_fetch_align.sv | 196 +++++++++++++++++++
 tb/tb_if_fetch_align.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m0_pkg.sv
// Shared types and constants for the Cortex-M0 fetch/align stage.
// Thumb-2 length prefixes, multi-cycle opcode masks and the align FSM states.
package m0_pkg;

    localparam logic [4:0] THUMB32_PREFIX_A = 5'b11101;
    localparam logic [4:0] THUMB32_PREFIX_B = 5'b11110;
    localparam logic [4:0] THUMB32_PREFIX_C = 5'b11111;

    localparam logic [15:0] LDMSTM_MASK   = 16'hF000;
    localparam logic [15:0] LDMSTM_MATCH  = 16'hC000;
    localparam logic [15:0] PUSHPOP_MASK  = 16'hF600;
    localparam logic [15:0] PUSHPOP_MATCH = 16'hB400;

    localparam logic [31:0] PC_READ_OFFSET = 32'd4;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } fa_state_e;

    function automatic logic is_thumb32(input logic [15:0] hw);
        return (hw[15:11] == THUMB32_PREFIX_A) ||
               (hw[15:11] == THUMB32_PREFIX_B) ||
               (hw[15:11] == THUMB32_PREFIX_C);
    endfunction

    function automatic logic is_multiple(input logic [15:0] hw);
        return ((hw & LDMSTM_MASK) == LDMSTM_MATCH) ||
               ((hw & PUSHPOP_MASK) == PUSHPOP_MATCH);
    endfunction

endpackage

// File: rtl/hw_queue.sv
// Circular halfword FIFO: pushes and pops of 0, 1 or 2 entries per cycle.
// Callers guarantee no overflow/underflow; flush empties it in one cycle.
module hw_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [1:0]                 push_cnt_i,
    input  logic [15:0]                push_lo_i,
    input  logic [15:0]                push_hi_i,
    input  logic [1:0]                 pop_cnt_i,
    output logic [15:0]                head0_o,
    output logic [15:0]                head1_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] rd_nxt, wr_nxt;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] p,
                                          input logic [1:0]    n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return AW'(s);
    endfunction

    assign rd_nxt  = adv(rd_q, 2'd1);
    assign wr_nxt  = adv(wr_q, 2'd1);
    assign head0_o = mem_q[rd_q];
    assign head1_o = mem_q[rd_nxt];
    assign count_o = cnt_q;

    always_comb begin
        rd_d  = adv(rd_q, pop_cnt_i);
        wr_d  = adv(wr_q, push_cnt_i);
        cnt_d = cnt_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push_cnt_i != 2'd0) mem_q[wr_q]   <= push_lo_i;
            if (push_cnt_i == 2'd2) mem_q[wr_nxt] <= push_hi_i;
        end
    end

endmodule

// File: rtl/if_fetch_align.sv
// Fetch/align stage: word fetches into a halfword queue, Thumb 16/32 issue,
// branch flush with stale-ack drop, and the LDM/STM/PUSH/POP hold protocol.
module if_fetch_align
    import m0_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH_HW = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        stall_in,
    input  logic        branch_valid_in,
    input  logic [31:0] branch_target_in,
    input  logic        multiple_done_in,
    output logic        valid_out,
    output logic [15:0] instruction16_out,
    output logic [31:0] instruction32_out,
    output logic        is32_out,
    output logic [31:0] pc_real_out,
    output logic        multiple_pulse_out,
    output logic        multiple_stable_out
);

    localparam int CW = $clog2(QDEPTH_HW + 1);

    fa_state_e state_q, state_d;

    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic        skip_q, skip_d;
    logic        drop_q, drop_d;

    logic        valid_q, valid_d;
    logic [15:0] i16_q, i16_d;
    logic [31:0] i32_q, i32_d;
    logic        is32_q, is32_d;
    logic [31:0] pc_real_q, pc_real_d;
    logic        mpulse_q, mpulse_d;
    logic        mstable_q, mstable_d;

    logic [15:0]   q_head0, q_head1;
    logic [CW-1:0] q_count;
    logic [1:0]    push_cnt, pop_cnt;
    logic [15:0]   push_lo;

    logic flush, accept, room;
    logic hw0_is32, hw0_multi, have_instr, issue;
    logic unused_tgt;

    assign unused_tgt = branch_target_in[0];

    hw_queue #(
        .DEPTH (QDEPTH_HW)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_cnt_i (push_cnt),
        .push_lo_i  (push_lo),
        .push_hi_i  (imem_rdata_in[31:16]),
        .pop_cnt_i  (pop_cnt),
        .head0_o    (q_head0),
        .head1_o    (q_head1),
        .count_o    (q_count)
    );

    assign flush      = branch_valid_in;
    assign accept     = req_q && imem_ack_in && !drop_q && !flush;
    assign room       = int'(q_count) <= QDEPTH_HW - 2;
    assign hw0_is32   = is_thumb32(q_head0);
    assign hw0_multi  = !hw0_is32 && is_multiple(q_head0);
    assign have_instr = hw0_is32 ? (q_count >= CW'(2))
                                 : (q_count >= CW'(1));
    assign issue      = (state_q == RUN) && !stall_in && !flush
                        && have_instr;

    assign pop_cnt  = !issue ? 2'd0 : (hw0_is32 ? 2'd2 : 2'd1);
    assign push_cnt = !accept ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
    assign push_lo  = skip_q ? imem_rdata_in[31:16] : imem_rdata_in[15:0];

    // A redirect never cancels a bus transfer; its data is dropped instead.
    always_comb begin
        req_d      = req_q ? !imem_ack_in : (room && !flush);
        addr_d     = req_q ? addr_q : fetch_pc_q;
        drop_d     = req_q && !imem_ack_in && (drop_q || flush);
        fetch_pc_d = fetch_pc_q;
        skip_d     = skip_q;
        head_pc_d  = head_pc_q;
        if (flush) begin
            fetch_pc_d = {branch_target_in[31:2], 2'b00};
            skip_d     = branch_target_in[1];
            head_pc_d  = {branch_target_in[31:1], 1'b0};
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                skip_d     = 1'b0;
            end
            if (issue)
                head_pc_d = head_pc_q + (hw0_is32 ? 32'd4 : 32'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = RUN;
        else if (issue && hw0_multi)
            state_d = MULTI;
        else if (state_q == MULTI && !stall_in && multiple_done_in)
            state_d = RUN;
    end

    always_comb begin
        valid_d   = valid_q;
        i16_d     = i16_q;
        i32_d     = i32_q;
        is32_d    = is32_q;
        pc_real_d = pc_real_q;
        mpulse_d  = mpulse_q;
        mstable_d = mstable_q;
        if (flush) begin
            valid_d   = 1'b0;
            mpulse_d  = 1'b0;
            mstable_d = 1'b0;
        end else if (!stall_in) begin
            if (issue) begin
                valid_d   = 1'b1;
                i16_d     = q_head0;
                i32_d     = {q_head0, hw0_is32 ? q_head1 : 16'h0000};
                is32_d    = hw0_is32;
                pc_real_d = head_pc_q + PC_READ_OFFSET;
                mpulse_d  = hw0_multi;
                mstable_d = hw0_multi;
            end else begin
                valid_d  = 1'b0;
                mpulse_d = 1'b0;
                if (state_q != MULTI || multiple_done_in)
                    mstable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            head_pc_q  <= {RESET_PC[31:1], 1'b0};
            skip_q     <= RESET_PC[1];
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            i16_q      <= '0;
            i32_q      <= '0;
            is32_q     <= 1'b0;
            pc_real_q  <= '0;
            mpulse_q   <= 1'b0;
            mstable_q  <= 1'b0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            skip_q     <= skip_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            i16_q      <= i16_d;
            i32_q      <= i32_d;
            is32_q     <= is32_d;
            pc_real_q  <= pc_real_d;
            mpulse_q   <= mpulse_d;
            mstable_q  <= mstable_d;
        end
    end

    assign imem_req_out        = req_q;
    assign imem_addr_out       = addr_q;
    assign valid_out           = valid_q;
    assign instruction16_out   = i16_q;
    assign instruction32_out   = i32_q;
    assign is32_out            = is32_q;
    assign pc_real_out         = pc_real_q;
    assign multiple_pulse_out  = mpulse_q;
    assign multiple_stable_out = mstable_q;

endmodule

// File: tb/tb_if_fetch_align.sv
// Directed bench for if_fetch_align: table of expected issues per memory
// image, plus hand sequences for latency, stall, branch drop and LDM/PUSH hold.
`timescale 1ns/1ps
module tb_if_fetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic        stall_in;
    logic        branch_valid_in;
    logic [31:0] branch_target_in;
    logic        multiple_done_in;
    logic        valid_out;
    logic [15:0] instruction16_out;
    logic [31:0] instruction32_out;
    logic        is32_out;
    logic [31:0] pc_real_out;
    logic        multiple_pulse_out;
    logic        multiple_stable_out;

    logic [31:0] mem [0:127];
    logic        ack_en;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          scen;
        logic [15:0] i16;
        logic [31:0] i32;
        logic        is32;
        logic [31:0] pc;
        logic        mp;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    assign imem_ack_in   = ack_en;
    assign imem_rdata_in = mem[imem_addr_out[8:2]];

    if_fetch_align #(
        .RESET_PC  (32'h0000_0000),
        .QDEPTH_HW (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_req_out        (imem_req_out),
        .imem_addr_out       (imem_addr_out),
        .imem_ack_in         (imem_ack_in),
        .imem_rdata_in       (imem_rdata_in),
        .stall_in            (stall_in),
        .branch_valid_in     (branch_valid_in),
        .branch_target_in    (branch_target_in),
        .multiple_done_in    (multiple_done_in),
        .valid_out           (valid_out),
        .instruction16_out   (instruction16_out),
        .instruction32_out   (instruction32_out),
        .is32_out            (is32_out),
        .pc_real_out         (pc_real_out),
        .multiple_pulse_out  (multiple_pulse_out),
        .multiple_stable_out (multiple_stable_out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_scen(input int s);
        for (int i = 0; i < 128; i++) mem[i] = 32'hBF00_BF00;
        case (s)
            0: begin mem[0] = 32'h2001_4800; mem[1] = 32'h4770_BF00; end
            1: begin mem[0] = 32'hF800_F000; mem[1] = 32'h0000_BF00; end
            2: begin mem[0] = 32'hF000_BF00; mem[1] = 32'hBF00_F800; end
            3: begin mem[0] = 32'h2001_B500; end
            default: ;
        endcase
        mem[7'h41] = 32'h2222_1111;
    endtask

    task automatic do_reset(input int s);
        rst              = 1'b1;
        stall_in         = 1'b0;
        branch_valid_in  = 1'b0;
        branch_target_in = 32'h0;
        multiple_done_in = 1'b0;
        ack_en           = 1'b1;
        load_scen(s);
        tick();
        tick();
        chk("reset_flags", {27'd0, valid_out, is32_out, multiple_pulse_out,
            multiple_stable_out, imem_req_out}, 32'h0);
        chk("reset_i16", {16'h0, instruction16_out}, 32'h0);
        chk("reset_pc", pc_real_out, 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_issue: valid_out got 0 expected 1");
        end
    endtask

    task automatic chk_issue(input string name, input logic [15:0] i16,
                             input logic [31:0] pc);
        bit ok;
        wait_issue(ok);
        if (ok) begin
            chk({name, "_i16"}, {16'h0, instruction16_out}, {16'h0, i16});
            chk({name, "_pc"}, pc_real_out, pc);
        end
    endtask

    initial begin
        bit ok;
        int cur;

        tbl[0]  = '{0, 16'h4800, 32'h0, 1'b0, 32'h4, 1'b0};
        tbl[1]  = '{0, 16'h2001, 32'h0, 1'b0, 32'h6, 1'b0};
        tbl[2]  = '{0, 16'hBF00, 32'h0, 1'b0, 32'h8, 1'b0};
        tbl[3]  = '{0, 16'h4770, 32'h0, 1'b0, 32'hA, 1'b0};
        tbl[4]  = '{0, 16'hBF00, 32'h0, 1'b0, 32'hC, 1'b0};
        tbl[5]  = '{1, 16'hF000, 32'hF000_F800, 1'b1, 32'h4, 1'b0};
        tbl[6]  = '{1, 16'hBF00, 32'h0, 1'b0, 32'h8, 1'b0};
        tbl[7]  = '{1, 16'h0000, 32'h0, 1'b0, 32'hA, 1'b0};
        tbl[8]  = '{2, 16'hBF00, 32'h0, 1'b0, 32'h4, 1'b0};
        tbl[9]  = '{2, 16'hF000, 32'hF000_F800, 1'b1, 32'h6, 1'b0};
        tbl[10] = '{2, 16'hBF00, 32'h0, 1'b0, 32'hA, 1'b0};

        cur = -1;
        for (int k = 0; k < NV; k++) begin
            if (tbl[k].scen != cur) begin
                cur = tbl[k].scen;
                do_reset(cur);
            end
            wait_issue(ok);
            if (ok) begin
                chk($sformatf("v%0d_i16", k), {16'h0, instruction16_out},
                    {16'h0, tbl[k].i16});
                chk($sformatf("v%0d_is32", k), {31'h0, is32_out},
                    {31'h0, tbl[k].is32});
                chk($sformatf("v%0d_pc", k), pc_real_out, tbl[k].pc);
                chk($sformatf("v%0d_mp", k), {31'h0, multiple_pulse_out},
                    {31'h0, tbl[k].mp});
                if (tbl[k].is32)
                    chk($sformatf("v%0d_i32", k), instruction32_out,
                        tbl[k].i32);
            end
        end

        // first-issue latency: valid two cycles after the first ack
        do_reset(0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req_out && imem_ack_in) begin
                ok = 1'b1;
                break;
            end
        end
        chk("lat_ack_seen", {31'h0, ok}, 32'h1);
        tick();
        chk("lat_valid_c1", {31'h0, valid_out}, 32'h0);
        tick();
        chk("lat_valid_c2", {31'h0, valid_out}, 32'h1);
        chk("lat_i16", {16'h0, instruction16_out}, 32'h4800);

        // stall mid-stream holds everything and loses nothing
        do_reset(0);
        chk_issue("st0", 16'h4800, 32'h4);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'h0, valid_out}, 32'h1);
            chk("stall_i16", {16'h0, instruction16_out}, 32'h4800);
            chk("stall_pc", pc_real_out, 32'h4);
        end
        stall_in = 1'b0;
        chk_issue("st1", 16'h2001, 32'h6);
        chk_issue("st2", 16'hBF00, 32'h8);
        chk_issue("st3", 16'h4770, 32'hA);

        // branch while a fetch is outstanding
        do_reset(0);
        ack_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("br_req_up", {31'h0, ok}, 32'h1);
        chk("br_old_addr", imem_addr_out, 32'h0);
        branch_valid_in  = 1'b1;
        branch_target_in = 32'h0000_0106;
        tick();
        branch_valid_in = 1'b0;
        tick();
        chk("br_req_held", {31'h0, imem_req_out}, 32'h1);
        chk("br_addr_held", imem_addr_out, 32'h0);
        chk("br_valid", {31'h0, valid_out}, 32'h0);
        ack_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("br_new_req", {31'h0, ok}, 32'h1);
        chk("br_new_addr", imem_addr_out, 32'h104);
        chk_issue("br0", 16'h2222, 32'h10A);
        chk_issue("br1", 16'hBF00, 32'h10C);

        // PUSH hold protocol
        do_reset(3);
        wait_issue(ok);
        if (ok) begin
            chk("mu_i16", {16'h0, instruction16_out}, 32'hB500);
            chk("mu_pulse", {31'h0, multiple_pulse_out}, 32'h1);
            chk("mu_stable", {31'h0, multiple_stable_out}, 32'h1);
            chk("mu_pc", pc_real_out, 32'h4);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mu_hold_valid", {31'h0, valid_out}, 32'h0);
            chk("mu_hold_pulse", {31'h0, multiple_pulse_out}, 32'h0);
            chk("mu_hold_stable", {31'h0, multiple_stable_out}, 32'h1);
        end
        multiple_done_in = 1'b1;
        tick();
        multiple_done_in = 1'b0;
        chk("mu_done_stable", {31'h0, multiple_stable_out}, 32'h0);
        chk("mu_done_valid", {31'h0, valid_out}, 32'h0);
        tick();
        chk("mu_resume_valid", {31'h0, valid_out}, 32'h1);
        chk("mu_resume_i16", {16'h0, instruction16_out}, 32'h2001);
        chk("mu_resume_pc", pc_real_out, 32'h6);

        // reset while in MULTI
        do_reset(3);
        chk_issue("mr0", 16'hB500, 32'h4);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_flags", {27'd0, valid_out, is32_out, multiple_pulse_out,
            multiple_stable_out, imem_req_out}, 32'h0);
        chk("mr_i16", {16'h0, instruction16_out}, 32'h0);
        chk("mr_pc", pc_real_out, 32'h0);
        rst = 1'b0;
        chk_issue("mr1", 16'hB500, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
